// File: rtl/alu_muldiv.sv
// Multi-cycle radix-2 unsigned multiply/divide unit with start/busy/done handshake.
// Define ALU_MULDIV_SIGNED_EN to enable two's-complement operation selected by op[2].
module alu_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic [4:0]  flags_out,
  output logic        div_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   a_q, a_d, am_q, am_d, bm_q, bm_d, rem_q, rem_d, out_q, out_d;
  logic [31:0]   acc_q, acc_d;
  logic [4:0]    flags_q, flags_d;
  logic          busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic          accept;
  logic [15:0]   mag_a, mag_b;
  logic [16:0]   mul_sum, rem_sh, diff;
  logic [31:0]   prod_f;
  logic [15:0]   quo_f, rem_f, res;
  logic          carry, ovf;

  assign accept = (state_q == S_IDLE) && start;

`ifdef ALU_MULDIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d, sovf_q, sovf_d;

  // Iterate on magnitudes; signs are captured at accept and re-applied in FIN.
  assign mag_a  = (op[2] && a_in[15]) ? -a_in : a_in;
  assign mag_b  = (op[2] && b_in[15]) ? -b_in : b_in;
  assign qneg_d = accept ? (op[2] & (a_in[15] ^ b_in[15])) : qneg_q;
  assign rneg_d = accept ? (op[2] & a_in[15]) : rneg_q;
  assign sovf_d = accept ? ((op == 3'b110) && (a_in == 16'h8000) && (b_in == 16'hFFFF)) : sovf_q;

  assign prod_f = qneg_q ? -acc_q : acc_q;
  assign quo_f  = qneg_q ? -acc_q[15:0] : acc_q[15:0];
  assign rem_f  = rneg_q ? -rem_q : rem_q;
  assign ovf    = dz_q | sovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      sovf_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      sovf_q <= sovf_d;
    end
  end
`else
  logic unused_op2;
  assign unused_op2 = op[2];
  assign mag_a  = a_in;
  assign mag_b  = b_in;
  assign prod_f = acc_q;
  assign quo_f  = acc_q[15:0];
  assign rem_f  = rem_q;
  assign ovf    = dz_q;
`endif

  // MUL: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, am_q} : 17'h0);
  // DIV: remainder stays below the divisor, so the 17-bit difference sign is the borrow.
  assign rem_sh  = {rem_q, acc_q[15]};
  assign diff    = rem_sh - {1'b0, bm_q};

  always_comb begin
    res   = 16'h0;
    carry = 1'b0;
    case (sel_q)
      2'b00: begin
        res   = prod_f[15:0];
        carry = |prod_f[31:16];
      end
      2'b01:   res = prod_f[31:16];
      2'b10:   res = dz_q ? 16'hFFFF : quo_f;
      default: res = dz_q ? a_q : rem_f;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    a_d     = a_q;
    am_d    = am_q;
    bm_d    = bm_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    out_d   = out_q;
    flags_d = flags_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          am_d    = mag_a;
          bm_d    = mag_b;
          sel_d   = op[1:0];
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = 16'h0;
          dz_d    = op[1] && (b_in == 16'h0);
          acc_d   = op[1] ? {16'h0, mag_a} : {16'h0, mag_b};
          state_d = (op[1] && (b_in == 16'h0)) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (sel_q[1]) begin
          acc_d = {16'h0, acc_q[14:0], ~diff[16]};
          rem_d = diff[16] ? rem_sh[15:0] : diff[15:0];
        end else begin
          acc_d = {mul_sum, acc_q[15:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        out_d   = res;
        flags_d = {^res, ovf, res[15], carry, ~|res};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      a_q     <= 16'h0;
      am_q    <= 16'h0;
      bm_q    <= 16'h0;
      rem_q   <= 16'h0;
      acc_q   <= 32'h0;
      out_q   <= 16'h0;
      flags_q <= 5'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign flags_out = flags_q;
  assign div_zero  = dz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes model results, a monitor pops on done.
// Signed cases run only when ALU_MULDIV_SIGNED_EN is defined.
module tb_alu_muldiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] a_in = 16'h0;
  logic [15:0] b_in = 16'h0;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic [4:0]  flags_out;
  logic        div_zero;

  typedef struct {
    logic [15:0] r;
    logic [4:0]  f;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ndone = 0;
  logic [15:0] cur_r = 16'h0;
  logic [15:0] held_r = 16'h0;

  alu_muldiv #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .out(out), .busy(busy), .done(done), .flags_out(flags_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands, signed when enabled and op[2] set.
  function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [31:0] p;
    logic [15:0] r;
    logic        c, s, ov;
    int          sa, sb, qi;
    s = 1'b0;
`ifdef ALU_MULDIV_SIGNED_EN
    s = o[2];
`endif
    sa   = s ? int'($signed(a)) : int'({16'h0, a});
    sb   = s ? int'($signed(b)) : int'({16'h0, b});
    p    = sa * sb;
    e.dz = o[1] && (b == 16'h0);
    c    = 1'b0;
    r    = 16'h0;
    case (o[1:0])
      2'b00: begin
        r = p[15:0];
        c = (p[31:16] != 16'h0);
      end
      2'b01: r = p[31:16];
      2'b10: begin
        if (e.dz) r = 16'hFFFF;
        else begin
          qi = sa / sb;
          r  = qi[15:0];
        end
      end
      default: begin
        if (e.dz) r = a;
        else begin
          qi = sa % sb;
          r  = qi[15:0];
        end
      end
    endcase
    ov    = e.dz | (s && (o[1:0] == 2'b10) && (a == 16'h8000) && (b == 16'hFFFF));
    e.r   = r;
    e.f   = {^r, ov, r[15], c, (r == 16'h0)};
    e.due = 0;
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e     = model(o, a, b);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.due = cyc + (e.dz ? 1 : 17);
    exp_q.push_back(e);
    held_r = cur_r;
    cur_r  = e.r;
    $display("ISSUE op=%0d a=%h b=%h expect out=%h flags=%b dz=%0d", o, a, b, e.r, e.f, e.dz);
    chk("busy_after_start", 32'(busy), 32'(1'b1));
    chk("div_zero_on_accept", 32'(div_zero), 32'(e.dz));
  endtask

  task automatic wait_done();
    int n0;
    bit got;
    n0  = ndone;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (ndone > n0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_40_cycles");
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done out=%h", out);
      end else begin
        e = exp_q.pop_front();
        $display("DONE out=%h flags=%b div_zero=%0d cycle=%0d", out, flags_out, div_zero, cyc);
        chk("out", 32'(out), 32'(e.r));
        chk("flags", 32'(flags_out), 32'(e.f));
        chk("div_zero", 32'(div_zero), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.due));
      end
      ndone++;
    end
  end

  logic [2:0]  d_op [9] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3, 3'd0};
  logic [15:0] d_a  [9] = '{16'h1234, 16'h1234, 16'd300, 16'd1000, 16'd1000, 16'd5, 16'h1234, 16'h1234, 16'h00FF};
  logic [15:0] d_b  [9] = '{16'h5678, 16'h5678, 16'd200, 16'd7, 16'd7, 16'd9, 16'h0000, 16'h0000, 16'h0003};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'(out), 32'(16'h0));
    chk("reset_busy", 32'(busy), 32'(1'b0));
    chk("reset_done", 32'(done), 32'(1'b0));
    chk("reset_flags", 32'(flags_out), 32'(5'h0));
    chk("reset_div_zero", 32'(div_zero), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      wait_done();
    end

    // start while busy is ignored; out holds the previous result during RUN
    issue(3'd0, 16'h1234, 16'h5678);
    repeat (4) @(posedge clk);
    #1;
    op    = 3'd2;
    a_in  = 16'hAAAA;
    b_in  = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("out_held_in_run", 32'(out), 32'(held_r));
    chk("busy_in_run", 32'(busy), 32'(1'b1));
    wait_done();
    // start presented during the done cycle is taken on the next edge
    issue(3'd3, 16'd1000, 16'd7);
    wait_done();

    // asynchronous reset in the middle of a multiply
    issue(3'd1, 16'hFFFF, 16'hFFFF);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    cur_r = 16'h0;
    chk("abort_out", 32'(out), 32'(16'h0));
    chk("abort_busy", 32'(busy), 32'(1'b0));
    chk("abort_done", 32'(done), 32'(1'b0));
    chk("abort_flags", 32'(flags_out), 32'(5'h0));
    chk("abort_div_zero", 32'(div_zero), 32'(1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd0, 16'd300, 16'd200);
    wait_done();

`ifdef ALU_MULDIV_SIGNED_EN
    issue(3'b110, 16'hFFF9, 16'h0002);
    wait_done();
    issue(3'b111, 16'hFFF9, 16'h0002);
    wait_done();
    issue(3'b110, 16'h8000, 16'hFFFF);
    wait_done();
    issue(3'b100, 16'hFFF9, 16'h0003);
    wait_done();
    issue(3'b110, 16'hFFF9, 16'h0000);
    wait_done();
`endif

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  ro;
      logic [15:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'h0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      issue(ro, ra, rb);
      wait_done();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
